// File: rtl/multdiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation codes,
// FSM states and iteration-counter sizing.
package multdiv_pkg;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [1:0] {OCIOSO, CALCULA, CONCLUI} estado_t;

  localparam int LARGURA_PADRAO = 32;
  // The counter must reach LARGURA itself, hence +1.
  localparam int CONT_W = $clog2(LARGURA_PADRAO + 1);

  function automatic int cont_largura(input int largura);
    return $clog2(largura + 1);
  endfunction

endpackage

// File: rtl/multdiv_passo.sv
// One radix-2 iteration on the {HI,LO} accumulator: shift-add for multiply,
// restoring shift-subtract for divide.
module multdiv_passo #(
  parameter int W = 32
) (
  input  logic           divide_i,
  input  logic [2*W-1:0] acc_i,
  input  logic [W-1:0]   oper_i,
  output logic [2*W-1:0] acc_o
);

  logic [W:0] soma;
  logic [W:0] parcial;
  logic [W:0] dif;

  assign soma    = {1'b0, acc_i[2*W-1:W]} + {1'b0, oper_i};
  // Partial remainder after the left shift needs one extra bit.
  assign parcial = acc_i[2*W-1:W-1];
  assign dif     = parcial - {1'b0, oper_i};

  always_comb begin
    acc_o = acc_i;
    if (!divide_i) begin
      if (acc_i[0]) acc_o = {soma, acc_i[W-1:1]};
      else          acc_o = {1'b0, acc_i[2*W-1:1]};
    end else begin
      if (parcial >= {1'b0, oper_i}) acc_o = {dif[W-1:0], acc_i[W-2:0], 1'b1};
      else                           acc_o = {acc_i[2*W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/unidade_mult_div.sv
// Iterative multiply/divide unit producing {HI,LO} with a one-cycle WriteHILO.
// Define MULTDIV_SIGNED_EN to enable signed mult/div (Operacao[0]=1).
module unidade_mult_div
  import multdiv_pkg::*;
#(
  parameter int LARGURA = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Inicia,
  input  logic [1:0]           Operacao,
  input  logic [LARGURA-1:0]   Operando_A,
  input  logic [LARGURA-1:0]   Operando_B,
  output logic [2*LARGURA-1:0] ResultadoHILO,
  output logic                 WriteHILO,
  output logic                 Ocupado
);

  localparam int W  = LARGURA;
  localparam int CW = cont_largura(LARGURA);

  estado_t        estado_q, estado_d;
  logic [CW-1:0]  cont_q, cont_d;
  logic [2*W-1:0] acc_q, acc_d, acc_passo, res_q, res_d, final_c;
  logic [W-1:0]   a_q, a_d, b_q, b_d, mag_a, mag_b;
  logic           div_q, div_d, write_q, write_d, ocup_q, ocup_d;
  logic           eh_div, aceita;

  assign eh_div = (Operacao == OP_DIVU) || (Operacao == OP_DIV);
  // CONCLUI also accepts, giving one operation every LARGURA+2 cycles.
  assign aceita = Inicia && (estado_q != CALCULA);

`ifdef MULTDIV_SIGNED_EN
  logic sa_q, sb_q, sa_n, sb_n, eh_sinal;

  assign eh_sinal = (Operacao == OP_MULT) || (Operacao == OP_DIV);
  assign sa_n     = eh_sinal & Operando_A[W-1];
  assign sb_n     = eh_sinal & Operando_B[W-1];
  assign mag_a    = sa_n ? -Operando_A : Operando_A;
  assign mag_b    = sb_n ? -Operando_B : Operando_B;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa_q <= 1'b0;
      sb_q <= 1'b0;
    end else if (aceita) begin
      sa_q <= sa_n;
      sb_q <= sb_n;
    end
  end

  always_comb begin
    final_c = acc_q;
    if (!div_q) begin
      if (sa_q ^ sb_q) final_c = -acc_q;
    end else if (b_q == '0) begin
      final_c = {a_q, {W{1'b1}}};
    end else begin
      if (sa_q ^ sb_q) final_c[W-1:0]   = -acc_q[W-1:0];
      if (sa_q)        final_c[2*W-1:W] = -acc_q[2*W-1:W];
    end
  end
`else
  assign mag_a = Operando_A;
  assign mag_b = Operando_B;

  always_comb begin
    final_c = acc_q;
    if (div_q && b_q == '0) final_c = {a_q, {W{1'b1}}};
  end
`endif

  multdiv_passo #(.W(W)) u_passo (
    .divide_i (div_q),
    .acc_i    (acc_q),
    .oper_i   (div_q ? b_q : a_q),
    .acc_o    (acc_passo)
  );

  always_comb begin
    estado_d = estado_q;
    cont_d   = cont_q;
    acc_d    = acc_q;
    a_d      = a_q;
    b_d      = b_q;
    div_d    = div_q;
    res_d    = res_q;
    write_d  = 1'b0;
    ocup_d   = ocup_q;
    case (estado_q)
      CALCULA: begin
        if (cont_q == CW'(LARGURA)) begin
          res_d    = final_c;
          write_d  = 1'b1;
          estado_d = CONCLUI;
        end else begin
          acc_d  = acc_passo;
          cont_d = cont_q + CW'(1);
        end
      end
      CONCLUI: begin
        ocup_d   = 1'b0;
        estado_d = OCIOSO;
      end
      default: estado_d = OCIOSO;
    endcase
    if (aceita) begin
      a_d      = mag_a;
      b_d      = mag_b;
      div_d    = eh_div;
      cont_d   = '0;
      acc_d    = eh_div ? {{W{1'b0}}, mag_a} : {{W{1'b0}}, mag_b};
      ocup_d   = 1'b1;
      estado_d = CALCULA;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q <= OCIOSO;
      cont_q   <= '0;
      acc_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      div_q    <= 1'b0;
      res_q    <= '0;
      write_q  <= 1'b0;
      ocup_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      cont_q   <= cont_d;
      acc_q    <= acc_d;
      a_q      <= a_d;
      b_q      <= b_d;
      div_q    <= div_d;
      res_q    <= res_d;
      write_q  <= write_d;
      ocup_q   <= ocup_d;
    end
  end

  assign ResultadoHILO = res_q;
  assign WriteHILO     = write_q;
  assign Ocupado       = ocup_q;

endmodule

// File: tb/tb_unidade_mult_div.sv
// Self-checking bench for unidade_mult_div: arithmetic reference model plus
// directed literal cases and randomized traffic.
module tb_unidade_mult_div;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          Inicia = 1'b0;
  logic [1:0]    Operacao = 2'b00;
  logic [W-1:0]  A = '0, B = '0;
  logic [2*W-1:0] ResultadoHILO;
  logic          WriteHILO, Ocupado;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  bit          m_ativo;
  int          m_k;
  logic [63:0] m_res, m_pend;

  unidade_mult_div #(.LARGURA(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .Inicia        (Inicia),
    .Operacao      (Operacao),
    .Operando_A    (A),
    .Operando_B    (B),
    .ResultadoHILO (ResultadoHILO),
    .WriteHILO     (WriteHILO),
    .Ocupado       (Ocupado)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] modelo(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bit     sig;
    longint sa, sb, q, r;
    sig = 1'b0;
`ifdef MULTDIV_SIGNED_EN
    sig = op[0];
`endif
    sa = sig ? longint'($signed(a)) : longint'({32'b0, a});
    sb = sig ? longint'($signed(b)) : longint'({32'b0, b});
    if (!op[1]) return 64'(sa * sb);
    if (b == 0) return {(sa < 0) ? 32'(-sa) : a, 32'hFFFFFFFF};
    q = sa / sb;
    r = sa % sb;
    return {32'(r), 32'(q)};
  endfunction

  task automatic checa(input string nome, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nome, got, exp, $time);
    end
  endtask

  // Reference timing: start at edge 0, result visible after edge W+1,
  // idle (or next start accepted) at edge W+2.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ativo <= 1'b0;
      m_k     <= 0;
      m_res   <= '0;
    end else begin
      if (m_ativo && m_k == W) m_res <= m_pend;
      if ((!m_ativo || m_k == W + 1) && Inicia) begin
        m_ativo <= 1'b1;
        m_k     <= 0;
        m_pend  <= modelo(Operacao, A, B);
      end else if (m_ativo) begin
        if (m_k == W + 1) m_ativo <= 1'b0;
        else              m_k <= m_k + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checa("ocupado", 64'(Ocupado), 64'(m_ativo));
      checa("write", 64'(WriteHILO), 64'(m_ativo && m_k == W + 1));
      checa("hilo", ResultadoHILO, m_res);
    end
  end

  task automatic esperar(input string nome, input logic [63:0] exp, input int ja);
    bit achou = 1'b0;
    for (int i = ja + 1; i <= W + 8; i++) begin
      @(posedge clk); #1;
      if (WriteHILO) begin
        checa({nome, "_lat"}, 64'(i), 64'(W + 1));
        checa(nome, ResultadoHILO, exp);
        achou = 1'b1;
        break;
      end
    end
    if (!achou) checa({nome, "_timeout"}, 64'd0, 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic inicia_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    Operacao = op; A = a; B = b; Inicia = 1'b1;
    @(posedge clk); #1;
    Inicia = 1'b0;
  endtask

  task automatic run_op(input string nome, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp);
    inicia_op(op, a, b);
    esperar(nome, exp, 0);
  endtask

  function automatic logic [31:0] sorteia();
    case ($urandom % 5)
      0:       return 32'($urandom % 16);
      1:       return 32'hFFFFFFFF - 32'($urandom % 8);
      2:       return 32'h0;
      default: return $urandom;
    endcase
  endfunction

  bit viu_write;

  initial begin
    #1 rst = 1'b1;
    #1 chk_en = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checa("reset_hilo", ResultadoHILO, 64'd0);
    checa("reset_ocupado", 64'(Ocupado), 64'd0);
    checa("reset_write", 64'(WriteHILO), 64'd0);

    run_op("multu_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
    run_op("divu_100_7", 2'b10, 32'd100, 32'd7, 64'h00000002_0000000E);
    run_op("divu_zero", 2'b10, 32'h00001234, 32'd0, 64'h00001234_FFFFFFFF);
`ifdef MULTDIV_SIGNED_EN
    run_op("mult_m3_4", 2'b01, 32'hFFFFFFFD, 32'd4, 64'hFFFFFFFF_FFFFFFF4);
    run_op("div_m7_2", 2'b11, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD);
`else
    run_op("op01_unsigned", 2'b01, 32'hFFFFFFFD, 32'd4, 64'h00000003_FFFFFFF4);
    run_op("op11_unsigned", 2'b11, 32'hFFFFFFF9, 32'd2, 64'h00000001_7FFFFFFC);
`endif

    // Start request while busy must be ignored.
    inicia_op(2'b00, 32'h12345678, 32'd9);
    repeat (4) @(posedge clk);
    #1; Operacao = 2'b10; A = 32'd5; B = 32'd0; Inicia = 1'b1;
    @(posedge clk); #1; Inicia = 1'b0;
    esperar("busy_ignored", 64'h00000000_A3D70A38, 5);

    // Asynchronous reset mid-operation aborts with no result pulse.
    inicia_op(2'b10, 32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checa("rst_ocupado", 64'(Ocupado), 64'd0);
    checa("rst_hilo", ResultadoHILO, 64'd0);
    @(negedge clk); rst = 1'b0;
    viu_write = 1'b0;
    repeat (W + 6) begin
      @(posedge clk); #1;
      if (WriteHILO) viu_write = 1'b1;
    end
    checa("rst_sem_write", 64'(viu_write), 64'd0);
    run_op("multu_6_7", 2'b00, 32'd6, 32'd7, 64'h00000000_0000002A);

    // Random traffic, including starts while busy.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      Inicia   = ($urandom % 6 == 0);
      Operacao = 2'($urandom);
      A        = sorteia();
      B        = sorteia();
    end
    // Continuous requests exercise back-to-back acceptance.
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      Inicia   = 1'b1;
      Operacao = 2'($urandom);
      A        = sorteia();
      B        = sorteia();
    end
    @(negedge clk); Inicia = 1'b0;
    repeat (W + 6) @(posedge clk);
    @(negedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
